// File: rtl/anc_pkg.sv
// Shared types and constants for the adaptive noise-cancellation datapath control.
package anc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_ERROR  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_OUTPUT = 3'd4
  } seq_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned RELOCK_SAMPLES_DEF = 48000;
  localparam int unsigned SAMPLE_W           = 16;
  localparam int unsigned WD_W               = 16;
  localparam int unsigned LOCK_W             = 24;
  localparam int unsigned SKIP_W             = 16;

  // States that wait on a done pulse and are guarded by the watchdog.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == ST_FILTER) || (s == ST_ERROR) || (s == ST_UPDATE);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Loadable countdown shared by the sequencer's wait states; expired pulses while
// enabled with the count at zero.
module phase_watchdog import anc_pkg::*; #(
  parameter int unsigned WIDTH = WD_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] load_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = load_i;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/anc_sample_sequencer.sv
// Per-sample control FSM: filter -> error -> optional LMS update -> output release,
// with watchdog abort, update gating and periodic error-calculator relock.
module anc_sample_sequencer import anc_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned RELOCK_SAMPLES = RELOCK_SAMPLES_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              sample_in,
  input  logic              nc_on,
  input  logic              clear_in,
  output logic              filter_start_out,
  input  logic              filter_done_in,
  output logic              error_ready_out,
  input  logic              error_done_in,
  input  logic              error_locked_in,
  output logic              error_rst_out,
  output logic              update_start_out,
  input  logic              update_done_in,
  output logic              sample_valid_out,
  output logic              busy_out,
  output logic              overrun_out,
  output logic              fault_out,
  output logic [SKIP_W-1:0] skipped_updates_out,
  output seq_state_t        dbg_state_out
);

  // Handshake: each start strobe is a registered single-cycle pulse; the matching
  // done is a single-cycle pulse accepted only while the FSM waits in that phase,
  // at the earliest one cycle after the strobe. Done wins over watchdog expiry.

  localparam logic [WD_W-1:0]   WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] RELOCK_N = LOCK_W'(RELOCK_SAMPLES);
  localparam logic              RELOCK_EN = (RELOCK_SAMPLES != 0);

  seq_state_t        state_q, state_d;
  logic              filter_start_q, filter_start_d;
  logic              error_ready_q, error_ready_d;
  logic              update_start_q, update_start_d;
  logic              sample_valid_q, sample_valid_d;
  logic              error_rst_q, error_rst_d;
  logic              overrun_q, overrun_d;
  logic              fault_q, fault_d;
  logic [SKIP_W-1:0] skipped_q, skipped_d;
  logic              relock_pend_q, relock_pend_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              nc_on_q;

  logic              enter_output;
  logic              abort;
  logic              skip_inc;
  logic              nc_rise;
  logic              relock_hit;
  logic              relock_fire;
  logic [LOCK_W-1:0] lock_next;
  logic              wd_clear;
  logic              wd_en;
  logic              wd_expired;

  assign nc_rise = nc_on && !nc_on_q;

  assign wd_en    = is_wait_state(state_q);
  assign wd_clear = is_wait_state(state_d) && (state_d != state_q);

  phase_watchdog #(.WIDTH(WD_W)) u_watchdog (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .load_i    (WD_LOAD),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d        = state_q;
    filter_start_d = 1'b0;
    error_ready_d  = 1'b0;
    update_start_d = 1'b0;
    sample_valid_d = 1'b0;
    error_rst_d    = 1'b0;
    enter_output   = 1'b0;
    abort          = 1'b0;
    skip_inc       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_in) begin
          filter_start_d = 1'b1;
          state_d        = ST_FILTER;
        end
      end
      ST_FILTER: begin
        if (filter_done_in) begin
          error_ready_d = 1'b1;
          state_d       = ST_ERROR;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      ST_ERROR: begin
        if (error_done_in) begin
          if (nc_on && !error_locked_in) begin
            update_start_d = 1'b1;
            state_d        = ST_UPDATE;
          end else begin
            skip_inc     = 1'b1;
            enter_output = 1'b1;
          end
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (update_done_in) begin
          enter_output = 1'b1;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      ST_OUTPUT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (enter_output) begin
      state_d        = ST_OUTPUT;
      sample_valid_d = 1'b1;
      error_rst_d    = relock_fire;
    end
    if (abort) begin
      state_d     = ST_IDLE;
      error_rst_d = 1'b1;
    end
  end

  // The locked-sample count advances as OUTPUT is entered so that the relock
  // reset it triggers lands in that same OUTPUT cycle.
  always_comb begin
    lock_next     = lock_cnt_q + 1'b1;
    relock_hit    = RELOCK_EN && error_locked_in && (lock_next >= RELOCK_N);
    relock_fire   = relock_pend_q || nc_rise || relock_hit;
    relock_pend_d = relock_pend_q || nc_rise;
    lock_cnt_d    = lock_cnt_q;
    if (enter_output) begin
      lock_cnt_d = error_locked_in ? lock_next : '0;
      if (relock_fire) begin
        relock_pend_d = 1'b0;
        lock_cnt_d    = '0;
      end
    end
    if (abort) begin
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    overrun_d = clear_in ? 1'b0 : overrun_q;
    fault_d   = clear_in ? 1'b0 : fault_q;
    skipped_d = clear_in ? '0 : skipped_q;
    if (sample_in && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
    if (abort) begin
      fault_d = 1'b1;
    end
    if (skip_inc && (skipped_d != {SKIP_W{1'b1}})) begin
      skipped_d = skipped_d + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      filter_start_q <= 1'b0;
      error_ready_q  <= 1'b0;
      update_start_q <= 1'b0;
      sample_valid_q <= 1'b0;
      error_rst_q    <= 1'b0;
      overrun_q      <= 1'b0;
      fault_q        <= 1'b0;
      skipped_q      <= '0;
      relock_pend_q  <= 1'b0;
      lock_cnt_q     <= '0;
      nc_on_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      filter_start_q <= filter_start_d;
      error_ready_q  <= error_ready_d;
      update_start_q <= update_start_d;
      sample_valid_q <= sample_valid_d;
      error_rst_q    <= error_rst_d;
      overrun_q      <= overrun_d;
      fault_q        <= fault_d;
      skipped_q      <= skipped_d;
      relock_pend_q  <= relock_pend_d;
      lock_cnt_q     <= lock_cnt_d;
      nc_on_q        <= nc_on;
    end
  end

  assign filter_start_out    = filter_start_q;
  assign error_ready_out     = error_ready_q;
  assign update_start_out    = update_start_q;
  assign sample_valid_out    = sample_valid_q;
  assign error_rst_out       = error_rst_q;
  assign busy_out            = (state_q != ST_IDLE);
  assign overrun_out         = overrun_q;
  assign fault_out           = fault_q;
  assign skipped_updates_out = skipped_q;
  assign dbg_state_out       = state_q;

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Directed bench for anc_sample_sequencer with an auto-responder for done pulses
// and hand-computed cycle expectations.
module tb_anc_sample_sequencer;
  import anc_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in, sample_in, nc_on, clear_in;
  logic              filter_start_out, filter_done_in;
  logic              error_ready_out, error_done_in, error_locked_in, error_rst_out;
  logic              update_start_out, update_done_in;
  logic              sample_valid_out, busy_out, overrun_out, fault_out;
  logic [15:0]       skipped_updates_out;
  seq_state_t        dbg_state_out;

  anc_sample_sequencer #(.TIMEOUT_CYCLES(8), .RELOCK_SAMPLES(4)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .sample_in           (sample_in),
    .nc_on               (nc_on),
    .clear_in            (clear_in),
    .filter_start_out    (filter_start_out),
    .filter_done_in      (filter_done_in),
    .error_ready_out     (error_ready_out),
    .error_done_in       (error_done_in),
    .error_locked_in     (error_locked_in),
    .error_rst_out       (error_rst_out),
    .update_start_out    (update_start_out),
    .update_done_in      (update_done_in),
    .sample_valid_out    (sample_valid_out),
    .busy_out            (busy_out),
    .overrun_out         (overrun_out),
    .fault_out           (fault_out),
    .skipped_updates_out (skipped_updates_out),
    .dbg_state_out       (dbg_state_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_bad = 0;
  int cyc = 0;
  int dly = 3;
  logic f_en = 1'b1;
  int f_due = -1, e_due = -1, u_due = -1;
  int inj_sample = -1, inj_nc_lo = -1, inj_nc_hi = -1;
  int last_filt = -1, last_err = -1, last_upd = -1, last_valid = -1, last_rst = -1;
  int n_err = 0, n_upd = 0, n_valid = 0, n_rst = 0, first_fault = -1;
  logic [31:0] rst_hist = '0;
  logic busy_first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: release pulse inputs, log strobes seen this cycle, drive due dones.
  task automatic tick();
    @(posedge clk_in); #1;
    cyc++;
    sample_in = 0; clear_in = 0;
    filter_done_in = 0; error_done_in = 0; update_done_in = 0;
    if (cyc == inj_sample) sample_in = 1;
    if (cyc == inj_nc_lo) nc_on = 0;
    if (cyc == inj_nc_hi) nc_on = 1;
    if (filter_start_out) begin last_filt = cyc; if (f_en) f_due = cyc + dly; end
    if (error_ready_out) begin last_err = cyc; n_err++; e_due = cyc + dly; end
    if (update_start_out) begin last_upd = cyc; n_upd++; u_due = cyc + dly; end
    if (sample_valid_out) begin
      last_valid = cyc; n_valid++;
      rst_hist = {rst_hist[30:0], error_rst_out};
    end
    if (error_rst_out) begin last_rst = cyc; n_rst++; end
    if (fault_out && first_fault < 0) first_fault = cyc;
    if (cyc == f_due) filter_done_in = 1;
    if (cyc == e_due) error_done_in = 1;
    if (cyc == u_due) update_done_in = 1;
  endtask

  task automatic run_sample(output int t0);
    sample_in = 1;
    t0 = cyc;
    tick();
    busy_first = busy_out;
    for (int i = 0; i < 200 && busy_out; i++) tick();
    chk("drain", {31'd0, busy_out}, 0);
  endtask

  function automatic logic [4:0] strobes();
    return {filter_start_out, error_ready_out, update_start_out, sample_valid_out, error_rst_out};
  endfunction

  initial begin
    int t0, base_v, base_u, base_r, base_e;
    rst_in = 1; sample_in = 0; nc_on = 0; clear_in = 0;
    filter_done_in = 0; error_done_in = 0; update_done_in = 0; error_locked_in = 0;
    repeat (3) tick();
    chk("rst_strobes", {27'd0, strobes()}, 0);
    chk("rst_busy", {31'd0, busy_out}, 0);
    rst_in = 0;
    tick();
    chk("post_rst_strobes", {27'd0, strobes()}, 0);
    chk("post_rst_sticky", {14'd0, overrun_out, fault_out, skipped_updates_out}, 0);

    // Nominal path, dones 3 cycles after each start; nc_on rise arms a relock.
    nc_on = 1; tick(); tick();
    dly = 3;
    run_sample(t0);
    chk("nom_busy", {31'd0, busy_first}, 1);
    chk("nom_filt", last_filt - t0, 1);
    chk("nom_err", last_err - t0, 5);
    chk("nom_upd", last_upd - t0, 9);
    chk("nom_valid", last_valid - t0, 13);
    chk("nom_relock", last_rst - t0, 13);
    chk("nom_skipped", {16'd0, skipped_updates_out}, 0);

    // Minimum latency with update, no relock pending anymore.
    dly = 1; base_r = n_rst;
    run_sample(t0);
    chk("min_lat_upd", last_valid - t0, 7);
    chk("min_no_rst", n_rst - base_r, 0);

    // Done arriving exactly on the watchdog expiry cycle is accepted.
    dly = 7;
    run_sample(t0);
    chk("edge_valid", last_valid - t0, 25);
    chk("edge_nofault", {31'd0, fault_out}, 0);

    // Locked bypass: 10 samples, relock on the 4th and 8th output.
    error_locked_in = 1; dly = 1; base_u = n_upd; rst_hist = '0;
    for (int k = 0; k < 10; k++) begin
      run_sample(t0);
      if (k == 0) chk("lock_lat", last_valid - t0, 5);
    end
    chk("lock_noupd", n_upd - base_u, 0);
    chk("lock_skipped", {16'd0, skipped_updates_out}, 10);
    chk("lock_relock", {22'd0, rst_hist[9:0]}, 32'h044);
    clear_in = 1; tick();
    chk("clr_skipped", {16'd0, skipped_updates_out}, 0);

    // Timeout: filter done withheld.
    error_locked_in = 0; f_en = 0; first_fault = -1; base_v = n_valid;
    run_sample(t0);
    chk("to_fault_cyc", first_fault - t0, 9);
    chk("to_rst_cyc", last_rst - t0, 9);
    chk("to_novalid", n_valid - base_v, 0);
    chk("to_idle", {29'd0, dbg_state_out}, {29'd0, ST_IDLE});
    f_en = 1;
    run_sample(t0);
    chk("to_recover", last_valid - t0, 7);
    chk("to_sticky", {31'd0, fault_out}, 1);

    // Overrun: second sample while in ERROR.
    dly = 3; base_v = n_valid;
    chk("ov_pre", {31'd0, overrun_out}, 0);
    inj_sample = cyc + 6;
    run_sample(t0);
    repeat (4) tick();
    chk("ov_set", {31'd0, overrun_out}, 1);
    chk("ov_one_valid", n_valid - base_v, 1);
    clear_in = 1; tick();
    chk("ov_clear", {31'd0, overrun_out}, 0);
    chk("fault_clear", {31'd0, fault_out}, 0);

    // nc_on rises during UPDATE: relock reset in the following OUTPUT.
    inj_nc_lo = cyc + 9; inj_nc_hi = cyc + 10;
    run_sample(t0);
    chk("nc_upd", last_upd - t0, 9);
    chk("nc_valid", last_valid - t0, 13);
    chk("nc_relock", last_rst - t0, 13);

    // Reset while in FILTER; the stray filter done that follows is ignored.
    sample_in = 1; t0 = cyc;
    tick();
    sample_in = 1;
    tick();
    chk("rf_overrun", {31'd0, overrun_out}, 1);
    rst_in = 1;
    tick();
    rst_in = 0;
    chk("rf_strobes", {27'd0, strobes()}, 0);
    chk("rf_flags", {29'd0, busy_out, overrun_out, fault_out}, 0);
    chk("rf_state", {29'd0, dbg_state_out}, {29'd0, ST_IDLE});
    base_e = n_err;
    repeat (5) tick();
    chk("rf_stray_err", n_err - base_e, 0);
    chk("rf_stray_busy", {31'd0, busy_out}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/anc_sample_sequencer.md
# anc_sample_sequencer

Per-sample control FSM for the adaptive noise-cancellation datapath. For each audio sample strobe it runs four phases in order: anti-noise filter compute, error calculation, LMS coefficient update when allowed, then output release. It holds each phase's one-cycle start strobe and waits for that phase's done pulse. It gates coefficient updates on `nc_on` and the error calculator's lock flag, and periodically re-arms lock detection by resetting the error calculator.

## Interface
- `TIMEOUT_CYCLES`, default 1024: max cycles to wait for any done pulse; valid range 2–65535.
- `RELOCK_SAMPLES`, default 48000: locked samples before a forced error-calculator reset; 0 disables; valid range 0–2^24-1.
- `clk_in`  in  1  system clock; sole clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `sample_in`  in  1  one-cycle strobe: new ADC/feedback sample available.
- `nc_on`  in  1  noise cancellation enable (level).
- `clear_in`  in  1  one-cycle strobe: clears sticky flags.
- `filter_start_out`  out  1  one-cycle start to the FIR filter.
- `filter_done_in`  in  1  filter done pulse.
- `error_ready_out`  out  1  one-cycle strobe to the error calculator.
- `error_done_in`  in  1  error calculator done pulse.
- `error_locked_in`  in  1  error calculator converged/locked flag.
- `error_rst_out`  out  1  one-cycle synchronous reset to the error calculator.
- `update_start_out`  out  1  one-cycle start to the LMS updater.
- `update_done_in`  in  1  LMS update done pulse.
- `sample_valid_out`  out  1  one-cycle: output sample for this strobe is final.
- `busy_out`  out  1  high whenever state ≠ IDLE.
- `overrun_out`  out  1  sticky: a sample strobe arrived while busy.
- `fault_out`  out  1  sticky: a phase timed out.
- `skipped_updates_out`  out  16  saturating count of samples whose LMS update was skipped.

## Operation
- States are IDLE, FILTER, ERROR, UPDATE, OUTPUT.
- IDLE, on `sample_in`: registered pulse of `filter_start_out`; go to FILTER.
- FILTER, on `filter_done_in`: pulse `error_ready_out`; go to ERROR.
- ERROR, on `error_done_in`:
  - If `nc_on && !error_locked_in`: pulse `update_start_out`; go to UPDATE.
  - Otherwise: increment `skipped_updates_out` (saturate at 0xFFFF); go to OUTPUT.
- UPDATE, on `update_done_in`: go to OUTPUT.
- OUTPUT, one cycle: assert `sample_valid_out`. Assert `error_rst_out` if relock is pending, then clear pending. Go to IDLE.
- Relock pending is set by either of:
  - a rising edge of `nc_on` (sampled in any state);
  - the locked-sample counter reaching `RELOCK_SAMPLES`. The counter increments at each OUTPUT while `error_locked_in` is high, clears when it is low, and clears when `error_rst_out` is issued.
- Done pulses that arrive in a state not waiting for them are ignored.
- Watchdog:
  - Counter clears on entry to FILTER, ERROR and UPDATE.
  - If it reaches `TIMEOUT_CYCLES` with no matching done, set `fault_out` and go to IDLE with no `sample_valid_out`.
  - Also pulse `error_rst_out` in that abort cycle so the datapath restarts clean.
- `sample_in` while state ≠ IDLE (OUTPUT included): the sample is dropped and `overrun_out` is set.
- `clear_in`: clears `overrun_out`, `fault_out` and `skipped_updates_out` next cycle. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - all strobe outputs 0;
  - `busy_out` 0, `overrun_out` 0, `fault_out` 0, `skipped_updates_out` 0;
  - state IDLE, relock pending 0, counters 0.
- Reset mid-phase aborts immediately. No strobe is emitted in the cycle after reset.
- Every output strobe is registered and fires exactly one cycle after its trigger:
  - `sample_in` at cycle t → `filter_start_out` at t+1;
  - done at cycle d → next strobe at d+1;
  - OUTPUT is entered at d+1 and `sample_valid_out` is high in that same cycle.
- Minimum latency, `sample_in` to `sample_valid_out`, when each done arrives the cycle after its start: 7 cycles with update, 5 without.
- A done pulse in the same cycle as its start strobe is not possible. The earliest accepted done is one cycle after the start strobe.
- A done that coincides with the watchdog expiry counts as done; there is no fault.
- `busy_out` is 1 from the cycle after accepted `sample_in` through the OUTPUT cycle.

## Structure
- Shared `anc_pkg` holds:
  - `seq_state_t` enum for the five states;
  - default constants for `TIMEOUT_CYCLES` and `RELOCK_SAMPLES`;
  - the 16-bit sample width constant shared with the error calculator.
- One sub-module, `phase_watchdog`: loadable countdown with `clear`, `enable`, and an `expired` pulse. It is instantiated once and shared by the three wait states.

## Test plan
- Nominal path:
  - Stimulus: `nc_on=1`, `error_locked_in=0`; each done returned 3 cycles after its start.
  - Response: strobes in order filter → error → update → valid; `sample_valid_out` 13 cycles after `sample_in`; `skipped_updates_out` stays 0.
- Locked bypass:
  - Stimulus: `error_locked_in=1`, 10 samples.
  - Response: no `update_start_out`; `skipped_updates_out=10`.
  - With `RELOCK_SAMPLES=4`: `error_rst_out` on the 4th and 8th OUTPUT cycles.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES=8`, `filter_done_in` withheld.
  - Response: `fault_out=1` and `error_rst_out` pulse 8 cycles after FILTER entry; return to IDLE with no valid; the next sample completes normally.
- Overrun:
  - Stimulus: second `sample_in` while in ERROR.
  - Response: `overrun_out=1`; only one `sample_valid_out`.
  - Then `clear_in` → `overrun_out=0`.
- `nc_on` edge plus reset mid-phase:
  - Stimulus: raise `nc_on` during UPDATE.
  - Response: `error_rst_out` in the following OUTPUT cycle.
  - Then assert `rst_in` in FILTER: all outputs 0 next cycle; a stray `filter_done_in` afterwards is ignored.
